axi4_lite_reg_slave: RTL and testbench

- AXI4-Lite responder that terminates transactions from the bridge's AXI master and implements the REG_TEST register window at 0x00001020–0x0000102C.
- Provides independent write and read channel state machines, byte-strobe writes, and SLVERR responses for out-of-window or misaligned accesses.
- Exports register contents and transaction counters for the UVM scoreboard and debug.
- Replaces the behavioural slave model in unit benches and is synthesisable for FPGA.

---
 rtl/axi4_lite_if.sv | 31 +++
 rtl/axi4_lite_reg_slave.sv | 191 +++++++++++++++++++
 tb/tb_axi4_lite_reg_slave.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_if.sv
// AXI4-Lite signal bundle shared by the register slave and its master.
// Address/data widths are fixed at 32 bits.
interface axi4_lite_if;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic [1:0]  bresp;
   logic        bready;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic        rvalid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
   );
endinterface

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register window with independent write/read FSMs, byte-strobe
// writes, SLVERR on out-of-window or misaligned accesses, and saturating counters.
//
// state        | meaning
// W_IDLE       | ready for AW and W, either order or together
// W_WAIT_DATA  | address latched, waiting for W
// W_WAIT_ADDR  | data/strobe latched, waiting for AW
// W_RESP       | write committed, bvalid held until bready
// R_IDLE       | ready for AR
// R_DATA       | rdata/rresp held until rready
module axi4_lite_reg_slave #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1020,
   parameter int          NUM_REGS    = 4,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   axi4_lite_if.slave               axi,
   output logic [NUM_REGS*32-1:0]   reg_out,
   output logic [NUM_REGS-1:0]      reg_wr_pulse,
   output logic [15:0]              wr_ok_count,
   output logic [15:0]              rd_ok_count,
   output logic [7:0]               err_count
);

   localparam int          IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * NUM_REGS);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_WAIT_DATA, W_WAIT_ADDR, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   w_state_t                 w_state;
   r_state_t                 r_state;
   logic [NUM_REGS*32-1:0]   regs_q;
   logic [31:0]              aw_addr_q;
   logic [31:0]              w_data_q;
   logic [3:0]               w_strb_q;

   logic                     aw_hs, w_hs, ar_hs;
   logic                     wr_commit, wr_hit, rd_hit;
   logic [31:0]              wr_addr, wr_data, rd_word;
   logic [3:0]               wr_strb;
   logic [IDX_W-1:0]         wr_idx, rd_idx;
   logic [1:0]               err_inc;
   logic [8:0]               err_sum;

   function automatic logic addr_hit(input logic [31:0] a);
      return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < END_ADDR) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
      return IDX_W'((a - BASE_ADDR) >> 2);
   endfunction

   assign reg_out = regs_q;

   always_comb begin
      aw_hs   = axi.awvalid & axi.awready;
      w_hs    = axi.wvalid & axi.wready;
      ar_hs   = axi.arvalid & axi.arready;
      // Each half of the write comes from the latch if it arrived earlier, else live.
      wr_addr = (w_state == W_WAIT_DATA) ? aw_addr_q : axi.awaddr;
      wr_data = (w_state == W_WAIT_ADDR) ? w_data_q : axi.wdata;
      wr_strb = (w_state == W_WAIT_ADDR) ? w_strb_q : axi.wstrb;
      wr_commit = 1'b0;
      case (w_state)
         W_IDLE:      wr_commit = aw_hs & w_hs;
         W_WAIT_DATA: wr_commit = w_hs;
         W_WAIT_ADDR: wr_commit = aw_hs;
         default:     wr_commit = 1'b0;
      endcase
      wr_hit  = addr_hit(wr_addr);
      wr_idx  = addr_idx(wr_addr);
      rd_hit  = addr_hit(axi.araddr);
      rd_idx  = addr_idx(axi.araddr);
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_idx == IDX_W'(i)) rd_word = regs_q[32*i +: 32];
      end
      err_inc = {1'b0, wr_commit & ~wr_hit} + {1'b0, ar_hs & ~rd_hit};
      err_sum = {1'b0, err_count} + 9'(err_inc);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state      <= W_IDLE;
         axi.awready  <= 1'b0;
         axi.wready   <= 1'b0;
         axi.bvalid   <= 1'b0;
         axi.bresp    <= 2'b00;
         aw_addr_q    <= '0;
         w_data_q     <= '0;
         w_strb_q     <= '0;
         regs_q       <= {NUM_REGS{RESET_VALUE}};
         reg_wr_pulse <= '0;
         wr_ok_count  <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (wr_commit) begin
            axi.bresp   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            axi.bvalid  <= 1'b1;
            axi.awready <= 1'b0;
            axi.wready  <= 1'b0;
            w_state     <= W_RESP;
            if (wr_hit) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  if (wr_idx == IDX_W'(i)) begin
                     reg_wr_pulse[i] <= 1'b1;
                     for (int k = 0; k < 4; k++) begin
                        if (wr_strb[k]) regs_q[32*i + 8*k +: 8] <= wr_data[8*k +: 8];
                     end
                  end
               end
               if (wr_ok_count != 16'hFFFF) wr_ok_count <= wr_ok_count + 16'd1;
            end
         end else begin
            case (w_state)
               W_IDLE: begin
                  if (aw_hs) begin
                     aw_addr_q   <= axi.awaddr;
                     axi.awready <= 1'b0;
                     axi.wready  <= 1'b1;
                     w_state     <= W_WAIT_DATA;
                  end else if (w_hs) begin
                     w_data_q    <= axi.wdata;
                     w_strb_q    <= axi.wstrb;
                     axi.awready <= 1'b1;
                     axi.wready  <= 1'b0;
                     w_state     <= W_WAIT_ADDR;
                  end else begin
                     axi.awready <= 1'b1;
                     axi.wready  <= 1'b1;
                  end
               end
               W_RESP: begin
                  if (axi.bready) begin
                     axi.bvalid  <= 1'b0;
                     axi.awready <= 1'b1;
                     axi.wready  <= 1'b1;
                     w_state     <= W_IDLE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // rd_word comes from regs_q before any same-edge write, so a colliding read sees old data.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= R_IDLE;
         axi.arready <= 1'b0;
         axi.rvalid  <= 1'b0;
         axi.rdata   <= '0;
         axi.rresp   <= 2'b00;
         rd_ok_count <= '0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (ar_hs) begin
                  axi.rdata   <= rd_hit ? rd_word : 32'h0;
                  axi.rresp   <= rd_hit ? RESP_OKAY : RESP_SLVERR;
                  axi.rvalid  <= 1'b1;
                  axi.arready <= 1'b0;
                  r_state     <= R_DATA;
                  if (rd_hit && rd_ok_count != 16'hFFFF) rd_ok_count <= rd_ok_count + 16'd1;
               end else begin
                  axi.arready <= 1'b1;
               end
            end
            R_DATA: begin
               if (axi.rready) begin
                  axi.rvalid  <= 1'b0;
                  axi.arready <= 1'b1;
                  r_state     <= R_IDLE;
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) err_count <= '0;
      else     err_count <= (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
   end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: handshake ordering, strobes, decode
// errors, backpressure, same-edge read/write collision and mid-response reset.
module tb_axi4_lite_reg_slave;
   localparam int NR = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [NR*32-1:0]  reg_out;
   logic [NR-1:0]     reg_wr_pulse;
   logic [15:0]       wr_ok_count, rd_ok_count;
   logic [7:0]        err_count;
   int                errors = 0;
   int                checks = 0;

   axi4_lite_if axi ();

   axi4_lite_reg_slave #(
      .BASE_ADDR   (32'h0000_1020),
      .NUM_REGS    (NR),
      .RESET_VALUE (32'h0000_0000)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .axi          (axi),
      .reg_out      (reg_out),
      .reg_wr_pulse (reg_wr_pulse),
      .wr_ok_count  (wr_ok_count),
      .rd_ok_count  (rd_ok_count),
      .err_count    (err_count)
   );

   always #4 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [NR-1:0] pulse);
      bit aw_pend = 1'b1;
      bit w_pend  = 1'b1;
      bit aw_go, w_go;
      int n = 0;
      axi.awaddr = addr; axi.wdata = data; axi.wstrb = strb;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
      while ((aw_pend || w_pend) && n < 20) begin
         aw_go = axi.awvalid && axi.awready;
         w_go  = axi.wvalid && axi.wready;
         step();
         if (aw_go) begin axi.awvalid = 1'b0; aw_pend = 1'b0; end
         if (w_go)  begin axi.wvalid = 1'b0;  w_pend = 1'b0;  end
         n++;
      end
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      chk("wr_handshake_done", {aw_pend, w_pend}, 2'b00);
      chk("wr_bvalid_latency", axi.bvalid, 1'b1);
      resp  = axi.bresp;
      pulse = reg_wr_pulse;
      axi.bready = 1'b1;
      step();
      axi.bready = 1'b0;
      chk("wr_bvalid_drop", axi.bvalid, 1'b0);
   endtask

   task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b1;
      while (!axi.arready && n < 20) begin step(); n++; end
      chk("rd_arready_seen", axi.arready, 1'b1);
      step();
      axi.arvalid = 1'b0;
      chk("rd_rvalid_latency", axi.rvalid, 1'b1);
      data = axi.rdata;
      resp = axi.rresp;
      step();
      axi.rready = 1'b0;
      chk("rd_rvalid_drop", axi.rvalid, 1'b0);
   endtask

   initial begin
      logic [1:0]    resp;
      logic [NR-1:0] pulse;
      logic [31:0]   data;

      rst = 1'b1;
      axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
      axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
      repeat (3) step();
      chk("rst_awready", axi.awready, 1'b0);
      chk("rst_arready", axi.arready, 1'b0);
      chk("rst_valids", {axi.bvalid, axi.rvalid}, 2'b00);
      chk("rst_resps", {axi.bresp, axi.rresp, axi.rdata}, 36'h0);
      chk("rst_reg_out", reg_out, 128'h0);
      chk("rst_counters", {wr_ok_count, rd_ok_count, err_count, reg_wr_pulse}, 44'h0);
      rst = 1'b0;
      step();
      chk("idle_readies", {axi.awready, axi.wready, axi.arready}, 3'b111);

      // AW and W together to 0x1020
      axi.awaddr = 32'h1020; axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      step();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      chk("t1_bvalid", axi.bvalid, 1'b1);
      chk("t1_bresp", axi.bresp, 2'b00);
      chk("t1_pulse", reg_wr_pulse, 4'b0001);
      chk("t1_resp_readies", {axi.awready, axi.wready}, 2'b00);
      chk("t1_reg0", reg_out[31:0], 32'h1234_5678);
      axi.bready = 1'b1;
      step();
      axi.bready = 1'b0;
      chk("t1_bvalid_drop", axi.bvalid, 1'b0);
      chk("t1_pulse_once", reg_wr_pulse, 4'b0000);
      do_read(32'h1020, data, resp);
      chk("t1_rdata", data, 32'h1234_5678);
      chk("t1_rresp", resp, 2'b00);
      chk("t1_counts", {wr_ok_count, rd_ok_count}, {16'd1, 16'd1});

      // W three cycles ahead of AW
      axi.wdata = 32'hDEAD_BEEF; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      step();
      axi.wvalid = 1'b0;
      chk("t2_wait_addr_readies", {axi.awready, axi.wready, axi.bvalid}, 3'b100);
      step(); step();
      chk("t2_wait_addr_hold", {axi.awready, axi.wready, axi.bvalid}, 3'b100);
      axi.awaddr = 32'h1024; axi.awvalid = 1'b1;
      step();
      axi.awvalid = 1'b0;
      chk("t2_w_first_b", {axi.bvalid, axi.bresp}, 3'b100);
      chk("t2_w_first_pulse", reg_wr_pulse, 4'b0010);
      axi.bready = 1'b1; step(); axi.bready = 1'b0;

      // AW ahead of W
      axi.awaddr = 32'h1028; axi.awvalid = 1'b1;
      step();
      axi.awvalid = 1'b0;
      chk("t2_wait_data_readies", {axi.awready, axi.wready, axi.bvalid}, 3'b010);
      step();
      axi.wdata = 32'hA5A5_0F0F; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
      step();
      axi.wvalid = 1'b0;
      chk("t2_aw_first_b", {axi.bvalid, axi.bresp}, 3'b100);
      chk("t2_aw_first_pulse", reg_wr_pulse, 4'b0100);
      axi.bready = 1'b1; step(); axi.bready = 1'b0;
      do_read(32'h1024, data, resp);
      chk("t2_rd_1024", {resp, data}, {2'b00, 32'hDEAD_BEEF});
      do_read(32'h1028, data, resp);
      chk("t2_rd_1028", {resp, data}, {2'b00, 32'hA5A5_0F0F});
      chk("t2_counts", {wr_ok_count, rd_ok_count}, {16'd3, 16'd3});

      // partial strobe
      do_write(32'h102C, 32'hFFFF_FFFF, 4'hF, resp, pulse);
      chk("t3_full_resp", resp, 2'b00);
      do_write(32'h102C, 32'h0000_0000, 4'h5, resp, pulse);
      chk("t3_strb_resp_pulse", {resp, pulse}, {2'b00, 4'b1000});
      do_read(32'h102C, data, resp);
      chk("t3_strb_rdata", {resp, data}, {2'b00, 32'hFF00_FF00});

      // decode errors
      do_write(32'h1030, 32'h5555_5555, 4'hF, resp, pulse);
      chk("t4_oow_write", {resp, pulse}, {2'b10, 4'b0000});
      do_write(32'h1022, 32'h6666_6666, 4'hF, resp, pulse);
      chk("t4_misaligned_write", {resp, pulse}, {2'b10, 4'b0000});
      do_read(32'h1000, data, resp);
      chk("t4_oow_read", {resp, data}, {2'b10, 32'h0});
      chk("t4_err_count", err_count, 8'd3);
      chk("t4_regs_unchanged", reg_out, {32'hFF00_FF00, 32'hA5A5_0F0F, 32'hDEAD_BEEF, 32'h1234_5678});
      chk("t4_ok_counts", {wr_ok_count, rd_ok_count}, {16'd5, 16'd4});

      // backpressure with a same-edge read/write of register 0
      axi.awaddr = 32'h1020; axi.wdata = 32'h1111_2222; axi.wstrb = 4'hF;
      axi.araddr = 32'h1020;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      step();
      chk("t5_collide_rdata_old", {axi.rvalid, axi.rresp, axi.rdata}, {1'b1, 2'b00, 32'h1234_5678});
      chk("t5_collide_b", {axi.bvalid, axi.bresp}, 3'b100);
      axi.awaddr = 32'h1024; axi.araddr = 32'h1024;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("t5_hold_b", {axi.bvalid, axi.bresp, axi.awready, axi.wready}, 5'b10000);
         chk("t5_hold_r", {axi.rvalid, axi.rresp, axi.rdata, axi.arready}, {1'b1, 2'b00, 32'h1234_5678, 1'b0});
      end
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      axi.bready = 1'b1; axi.rready = 1'b1;
      step();
      axi.bready = 1'b0; axi.rready = 1'b0;
      chk("t5_release", {axi.bvalid, axi.rvalid}, 2'b00);
      chk("t5_counts", {wr_ok_count, rd_ok_count}, {16'd6, 16'd5});
      do_read(32'h1020, data, resp);
      chk("t5_new_value", {resp, data}, {2'b00, 32'h1111_2222});

      // write and read SLVERR on the same edge
      axi.awaddr = 32'h1030; axi.wdata = 32'h7777_7777; axi.wstrb = 4'hF; axi.araddr = 32'h1000;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
      step();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
      chk("t5_dual_err_count", err_count, 8'd5);
      chk("t5_dual_err_resps", {axi.bresp, axi.rresp, axi.rdata}, {2'b10, 2'b10, 32'h0});
      axi.bready = 1'b1; axi.rready = 1'b1;
      step();
      axi.bready = 1'b0; axi.rready = 1'b0;

      // reset while bvalid is pending
      axi.awaddr = 32'h1028; axi.wdata = 32'hCAFE_BABE; axi.wstrb = 4'hF;
      axi.awvalid = 1'b1; axi.wvalid = 1'b1;
      step();
      axi.awvalid = 1'b0; axi.wvalid = 1'b0;
      chk("t6_pre_rst_b", {axi.bvalid, reg_out[95:64]}, {1'b1, 32'hCAFE_BABE});
      rst = 1'b1;
      step();
      chk("t6_rst_bvalid", axi.bvalid, 1'b0);
      chk("t6_rst_regs", reg_out, 128'h0);
      chk("t6_rst_counts", {wr_ok_count, rd_ok_count, err_count}, 40'h0);
      rst = 1'b0;
      step();
      do_write(32'h1028, 32'hCAFE_BABE, 4'hF, resp, pulse);
      chk("t6_reissue", {resp, pulse, reg_out[95:64]}, {2'b00, 4'b0100, 32'hCAFE_BABE});
      chk("t6_reissue_count", wr_ok_count, 16'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
